ahb_bus_arbiter: RTL and testbench

- Round-robin AHB bus arbiter for up to NUM_MASTERS master instances (e.g. several MASTER_TOP-style FSM/ALU masters) sharing one AHB-Lite slave fabric.
- Issues registered one-hot HGRANT and the address-phase / data-phase master indices used by the fabric's HADDR/HWDATA/control muxes.
- Never breaks a burst or locked sequence; bounds any one master's tenure while others wait.

---
 rtl/ahb_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB-Lite bus arbiter.
// Holds the grant across bursts (BUSY/SEQ) and locked sequences. Once an owner
// has completed MAX_TENURE beats, it yields to the next waiting requester.
// HGRANT is registered one-hot. HMASTER and HMASTER_D form the address-phase
// and data-phase steering pipeline, and they advance only on HREADY.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int MW             = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_TENURE     = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  input  logic                   HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic [MW-1:0]          HMASTER_D,
  output logic                   HMASTLOCK
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  // PARK: the default master holds the grant and nobody needs the bus.
  typedef enum logic {
    ST_PARK,
    ST_OWNED
  } arb_state_e;

  localparam logic [MW-1:0] DEF_IDX    = MW'(DEFAULT_MASTER);
  localparam logic [7:0]    TENURE_MAX = 8'(MAX_TENURE);

  // Registered state.
  logic [MW-1:0]          owner_q,     owner_d;
  logic [NUM_MASTERS-1:0] grant_q,     grant_d;
  logic [7:0]             tenure_q,    tenure_d;
  logic [MW-1:0]          hmaster_q,   hmaster_d;
  logic [MW-1:0]          hmaster_dp_q, hmaster_dp_d;
  logic                   mastlock_q,  mastlock_d;

  // Combinational decode.
  htrans_e                trans;
  arb_state_e             state;
  logic                   rearb_ok;
  logic                   others_req;
  logic                   tenure_done;
  logic                   beat_done;
  logic                   rr_found;
  logic [MW-1:0]          rr_idx;
  logic [MW-1:0]          cand;

  assign trans       = htrans_e'(HTRANS);
  assign others_req  = |(HBUSREQ & ~grant_q);
  assign tenure_done = (tenure_q >= TENURE_MAX);
  assign beat_done   = HREADY & HTRANS[1];

  // A handover is safe only at a transfer boundary: never inside a burst or a
  // locked sequence. An ERROR response is the exception, because it aborts the burst.
  assign rearb_ok = HREADY & ~HLOCK[owner_q] &
                    ((trans == TR_IDLE) | (trans == TR_NONSEQ) | HRESP);

  assign state = ((owner_q == DEF_IDX) && !HBUSREQ[owner_q]) ? ST_PARK : ST_OWNED;

  // Round-robin search over the other masters, starting at owner+1 and wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    rr_found = 1'b0;
    rr_idx   = owner_q;
    cand     = '0;
    for (int i = 1; i < NUM_MASTERS; i++) begin
      cand = MW'((int'(owner_q) + i) % NUM_MASTERS);
      if (!rr_found && HBUSREQ[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Next owner, grant, tenure and handover pipeline.
  always_comb begin
    owner_d      = owner_q;
    hmaster_d    = hmaster_q;
    hmaster_dp_d = hmaster_dp_q;
    mastlock_d   = mastlock_q;
    tenure_d     = tenure_q;

    case (state)
      ST_PARK: begin
        if (rearb_ok && rr_found) begin
          owner_d = rr_idx;
        end
      end
      default: begin
        if (rearb_ok) begin
          if (!HBUSREQ[owner_q]) begin
            // The owner is done: pass to the next requester, otherwise return to park.
            owner_d = rr_found ? rr_idx : DEF_IDX;
          end else if (others_req && tenure_done) begin
            owner_d = rr_idx;
          end
        end
      end
    endcase

    grant_d          = '0;
    grant_d[owner_d] = 1'b1;

    if (owner_d != owner_q) begin
      tenure_d = '0;
    end else if (beat_done && !tenure_done) begin
      tenure_d = tenure_q + 8'd1;
    end

    // The address phase follows the grant, and the data phase follows the address phase.
    if (HREADY) begin
      hmaster_d    = owner_q;
      mastlock_d   = HLOCK[owner_q];
      hmaster_dp_d = hmaster_q;
    end
  end

  // State registers with synchronous reset; the default master is granted out of reset.
  always_ff @(posedge HCLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value without any order dependence.
    if (HRESET) begin
      owner_q      <= DEF_IDX;
      grant_q      <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      tenure_q     <= '0;
      hmaster_q    <= DEF_IDX;
      hmaster_dp_q <= DEF_IDX;
      mastlock_q   <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      tenure_q     <= tenure_d;
      hmaster_q    <= hmaster_d;
      hmaster_dp_q <= hmaster_dp_d;
      mastlock_q   <= mastlock_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = hmaster_q;
  assign HMASTER_D = hmaster_dp_q;
  assign HMASTLOCK = mastlock_q;

  a_grant_onehot : assert property (@(posedge HCLK) disable iff (HRESET) $onehot(HGRANT));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed scenarios checked against fixed expectations,
// followed by randomized traffic checked against a behavioural arbiter model.
module tb_ahb_bus_arbiter;

  localparam int N    = 4;
  localparam int MW   = 2;
  localparam int DEF  = 0;
  localparam int MAXT = 16;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic          HCLK    = 1'b0;
  logic          HRESET  = 1'b1;
  logic [N-1:0]  HBUSREQ = '0;
  logic [N-1:0]  HLOCK   = '0;
  logic [1:0]    HTRANS  = IDLE;
  logic          HREADY  = 1'b1;
  logic          HRESP   = 1'b0;
  logic [N-1:0]  HGRANT;
  logic [MW-1:0] HMASTER;
  logic [MW-1:0] HMASTER_D;
  logic          HMASTLOCK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: the owner index, the completed-beat count, and the
  // two pipeline stages.
  int m_owner = DEF;
  int m_ten   = 0;
  int m_hm    = DEF;
  int m_hmd   = DEF;
  bit m_lock  = 1'b0;

  ahb_bus_arbiter #(
    .NUM_MASTERS(N), .MW(MW), .DEFAULT_MASTER(DEF), .MAX_TENURE(MAXT)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP), .HGRANT(HGRANT),
    .HMASTER(HMASTER), .HMASTER_D(HMASTER_D), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  // First requester after 'from' in circular order, or -1 if there is none.
  function automatic int rr_pick(int from, logic [N-1:0] req);
    for (int k = 1; k < N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit ok;
    bit beat;
    int w;
    int nxt;
    if (HRESET) begin
      m_owner = DEF; m_ten = 0; m_hm = DEF; m_hmd = DEF; m_lock = 1'b0;
      return;
    end
    ok   = HREADY && !HLOCK[m_owner] && (HTRANS == IDLE || HTRANS == NONSEQ || HRESP);
    beat = HREADY && (HTRANS == NONSEQ || HTRANS == SEQ);
    w    = rr_pick(m_owner, HBUSREQ);
    nxt  = m_owner;
    if (ok && !HBUSREQ[m_owner]) nxt = (w < 0) ? DEF : w;
    else if (ok && w >= 0 && m_ten >= MAXT) nxt = w;
    if (HREADY) begin
      m_hmd  = m_hm;
      m_hm   = m_owner;
      m_lock = HLOCK[m_owner];
    end
    if (nxt != m_owner) m_ten = 0;
    else if (beat) m_ten = (m_ten + 1 > MAXT) ? MAXT : m_ten + 1;
    m_owner = nxt;
  endtask

  // Advance one edge. Inputs change only 1 ns after an edge, so they are stable at the edge.
  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HBUSREQ = 4'b1111;
    repeat (2) tick();
    vectors++; if (HGRANT !== 4'b0001) begin miscompares++; $display("FAIL reset_hgrant: got %b want 0001", HGRANT); end
    vectors++; if (HMASTER !== 2'd0) begin miscompares++; $display("FAIL reset_hmaster: got %0d want 0", HMASTER); end
    vectors++; if (HMASTER_D !== 2'd0) begin miscompares++; $display("FAIL reset_hmaster_d: got %0d want 0", HMASTER_D); end
    vectors++; if (HMASTLOCK !== 1'b0) begin miscompares++; $display("FAIL reset_mastlock: got %b want 0", HMASTLOCK); end
    HRESET = 1'b0; HBUSREQ = 4'b1110; HTRANS = IDLE; HREADY = 1'b1;
    tick();
    vectors++; if (HGRANT !== 4'b0010) begin miscompares++; $display("FAIL reset_first_grant: got %b want 0010", HGRANT); end
  endtask

  task automatic test_round_robin();
    int seq [3] = '{1, 2, 3};
    int cur;
    int nxt;
    HBUSREQ = 4'b1110; HTRANS = NONSEQ; HREADY = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cur = seq[r];
      nxt = (r == 2) ? 1 : seq[r + 1];
      for (int t = 1; t <= MAXT; t++) begin
        tick();
        if (t == 1) begin
          vectors++; if (HMASTER !== MW'(cur)) begin miscompares++; $display("FAIL rr_hmaster: got %0d want %0d", HMASTER, cur); end
        end
        if (t == 2) begin
          vectors++; if (HMASTER_D !== MW'(cur)) begin miscompares++; $display("FAIL rr_hmaster_d: got %0d want %0d", HMASTER_D, cur); end
        end
        if (t == MAXT) begin
          vectors++; if (HGRANT !== N'(1 << cur)) begin miscompares++; $display("FAIL rr_hold: got %b want %b", HGRANT, N'(1 << cur)); end
        end
      end
      tick();
      vectors++; if (HGRANT !== N'(1 << nxt)) begin miscompares++; $display("FAIL rr_rotate: got %b want %b", HGRANT, N'(1 << nxt)); end
    end
  endtask

  task automatic test_burst();
    logic [1:0] tr  [6] = '{NONSEQ, SEQ, SEQ, SEQ, SEQ, SEQ};
    logic       rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    HRESET = 1'b1; HBUSREQ = '0; HTRANS = IDLE; HREADY = 1'b1;
    tick();
    HRESET = 1'b0; HBUSREQ = 4'b0100;
    tick();
    vectors++; if (HGRANT !== 4'b0100) begin miscompares++; $display("FAIL burst_grant2: got %b want 0100", HGRANT); end
    for (int k = 0; k < 6; k++) begin
      // The burst owner drops its request after NONSEQ. The SEQ beats must still keep the grant.
      HBUSREQ = (k == 0) ? 4'b1100 : 4'b1000;
      HTRANS = tr[k]; HREADY = rdy[k];
      tick();
      vectors++; if (HGRANT !== 4'b0100) begin miscompares++; $display("FAIL burst_hold[%0d]: got %b want 0100", k, HGRANT); end
      vectors++; if (HMASTER !== 2'd2) begin miscompares++; $display("FAIL burst_hmaster[%0d]: got %0d want 2", k, HMASTER); end
    end
    HTRANS = IDLE; HREADY = 1'b1;
    tick();
    vectors++; if (HGRANT !== 4'b1000) begin miscompares++; $display("FAIL burst_handover: got %b want 1000", HGRANT); end
  endtask

  task automatic test_lock();
    int err_at;
    HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HREADY = 1'b1;
    tick();
    HRESET = 1'b0; HBUSREQ = 4'b0010; HLOCK = 4'b0010;
    tick();
    vectors++; if (HGRANT !== 4'b0010) begin miscompares++; $display("FAIL lock_grant1: got %b want 0010", HGRANT); end
    HBUSREQ = 4'b1110;
    err_at = $urandom_range(5, 35);
    for (int k = 0; k < 40; k++) begin
      HTRANS = (k == 0 || $urandom_range(0, 1) == 0) ? NONSEQ : SEQ;
      HRESP  = (k == err_at);
      tick();
      vectors++; if (HGRANT !== 4'b0010) begin miscompares++; $display("FAIL lock_hold[%0d]: got %b want 0010", k, HGRANT); end
      vectors++; if (HMASTLOCK !== 1'b1) begin miscompares++; $display("FAIL lock_mastlock[%0d]: got %b want 1", k, HMASTLOCK); end
    end
    HRESP = 1'b0; HLOCK = '0; HTRANS = NONSEQ;
    tick();
    vectors++; if (HGRANT !== 4'b0100) begin miscompares++; $display("FAIL lock_release: got %b want 0100", HGRANT); end
    vectors++; if (HMASTLOCK !== 1'b0) begin miscompares++; $display("FAIL lock_mastlock_off: got %b want 0", HMASTLOCK); end
  endtask

  task automatic test_tenure();
    HRESET = 1'b1; HBUSREQ = '0; HTRANS = IDLE; HREADY = 1'b1;
    tick();
    HRESET = 1'b0; HBUSREQ = 4'b1001; HTRANS = NONSEQ;
    for (int t = 1; t <= MAXT; t++) begin
      tick();
      vectors++; if (HGRANT !== 4'b0001) begin miscompares++; $display("FAIL tenure_hold[%0d]: got %b want 0001", t, HGRANT); end
    end
    tick();
    vectors++; if (HGRANT !== 4'b1000) begin miscompares++; $display("FAIL tenure_yield: got %b want 1000", HGRANT); end
  endtask

  task automatic test_park_reset();
    HBUSREQ = '0; HTRANS = IDLE; HREADY = 1'b1;
    tick();
    vectors++; if (HGRANT !== 4'b0001) begin miscompares++; $display("FAIL park_return: got %b want 0001", HGRANT); end
    HBUSREQ = 4'b0100;
    tick();
    vectors++; if (HGRANT !== 4'b0100) begin miscompares++; $display("FAIL park_grant2: got %b want 0100", HGRANT); end
    HTRANS = NONSEQ; tick();
    HTRANS = SEQ;    tick();
    HRESET = 1'b1;
    tick();
    vectors++; if (HGRANT !== 4'b0001) begin miscompares++; $display("FAIL midreset_hgrant: got %b want 0001", HGRANT); end
    vectors++; if (HMASTER !== 2'd0) begin miscompares++; $display("FAIL midreset_hmaster: got %0d want 0", HMASTER); end
    vectors++; if (HMASTER_D !== 2'd0) begin miscompares++; $display("FAIL midreset_hmaster_d: got %0d want 0", HMASTER_D); end
    vectors++; if (HMASTLOCK !== 1'b0) begin miscompares++; $display("FAIL midreset_mastlock: got %b want 0", HMASTLOCK); end
    HRESET = 1'b0; HBUSREQ = '0; HTRANS = IDLE;
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    for (int c = 0; c < 3000; c++) begin
      HRESET  = ($urandom_range(0, 199) == 0);
      HBUSREQ = N'($urandom);
      HLOCK   = N'($urandom & $urandom & $urandom);
      HTRANS  = 2'($urandom);
      HREADY  = ($urandom_range(0, 3) != 0);
      HRESP   = ($urandom_range(0, 15) == 0);
      tick();
      eg = '0; eg[m_owner] = 1'b1;
      vectors++; if (HGRANT !== eg) begin miscompares++; $display("FAIL rand_hgrant[%0d]: got %b want %b", c, HGRANT, eg); end
      vectors++; if (HMASTER !== MW'(m_hm)) begin miscompares++; $display("FAIL rand_hmaster[%0d]: got %0d want %0d", c, HMASTER, m_hm); end
      vectors++; if (HMASTER_D !== MW'(m_hmd)) begin miscompares++; $display("FAIL rand_hmaster_d[%0d]: got %0d want %0d", c, HMASTER_D, m_hmd); end
      vectors++; if (HMASTLOCK !== m_lock) begin miscompares++; $display("FAIL rand_mastlock[%0d]: got %b want %b", c, HMASTLOCK, m_lock); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_lock();
    test_tenure();
    test_park_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
